// File: rtl/tcp_client_controller.sv
// Active-open TCP client control FSM: opens one connection, ACKs in-order data and closes it,
// handing control-segment headers (SYN, ACK, FIN+ACK, RST) to the TCP header TX builder.
module tcp_client_controller #(
  parameter logic [15:0] LOCAL_PORT       = 16'hF719,
  parameter logic [15:0] REMOTE_PORT      = 16'h1F90,
  parameter logic [31:0] ISS              = 32'h0,
  parameter logic [31:0] RTO_CYCLES       = 32'd125000000,
  parameter logic [31:0] MAX_RETRIES      = 32'd3,
  parameter logic [31:0] TIME_WAIT_CYCLES = 32'd250000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        open_i,
  input  logic        close_i,
  input  logic        tcp_op_rcv_i,
  input  logic [15:0] tcp_source_port_i,
  input  logic [15:0] tcp_dest_port_i,
  input  logic [5:0]  tcp_flags_i,
  input  logic [31:0] tcp_seq_num_i,
  input  logic [31:0] tcp_ack_num_i,
  input  logic [15:0] tcp_data_len_i,
  input  logic [15:0] tcp_window_i,
  output logic        tcp_op_rcv_rd_o,
  input  logic        trnsmt_busy_i,
  output logic        tcp_start_o,
  output logic [15:0] tcp_source_port_o,
  output logic [15:0] tcp_dest_port_o,
  output logic [5:0]  tcp_flags_o,
  output logic [31:0] tcp_seq_num_o,
  output logic [31:0] tcp_ack_num_o,
  output logic [3:0]  tcp_head_len_o,
  output logic [15:0] tcp_data_len_o,
  output logic        rx_data_ok_o,
  output logic [15:0] rx_data_len_o,
  output logic [15:0] peer_window_o,
  output logic [7:0]  state_o,
  output logic        error_o
);

  typedef enum logic [7:0] {
    CLOSED      = 8'h01, SYN_SENT  = 8'h02, ESTABLISHED = 8'h04, FIN_WAIT1 = 8'h08,
    FIN_WAIT2   = 8'h10, CLOSING   = 8'h20, TIME_WAIT   = 8'h40, LAST_ACK  = 8'h80
  } state_t;

  localparam logic [5:0] F_FIN = 6'h01, F_SYN = 6'h02, F_RST = 6'h04, F_ACK = 6'h10;

  typedef struct packed {
    logic [5:0]  flags;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [3:0]  head_len;
  } hdr_t;

  localparam hdr_t HDR_RESET = '{flags: 6'h0, seq: 32'h0, ack: 32'h0, head_len: 4'd5};

  function automatic hdr_t mk(input logic [5:0] fl, input logic [31:0] sq,
                              input logic [31:0] ak, input logic [3:0] hl);
    mk = '{flags: fl, seq: sq, ack: ak, head_len: hl};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] snd_nxt_q, snd_nxt_d, rcv_nxt_q, rcv_nxt_d, tmr_q, retries_q;
  logic        rd_q, pend_q, close_q, rx_ok_q, err_q;
  logic [15:0] rx_len_q, win_q;
  hdr_t        pend_hdr_q, out_hdr_q, snd_hdr, hdr_view;
  logic        send, data_ok, win_upd, err, tmr_clr, retry_inc, close_take;

  logic        seg_ev, seg_ok, f_ack, f_rst, f_syn, f_fin, seq_ok, ack_hit;
  logic        rx_state, timed, rto_exp, tw_exp, close_req;
  logic [31:0] seg_end;

  assign seg_ev    = tcp_op_rcv_i & rd_q;
  assign seg_ok    = seg_ev & (tcp_source_port_i == REMOTE_PORT) & (tcp_dest_port_i == LOCAL_PORT);
  assign f_ack     = tcp_flags_i[4];
  assign f_rst     = tcp_flags_i[2];
  assign f_syn     = tcp_flags_i[1];
  assign f_fin     = tcp_flags_i[0];
  assign seq_ok    = (tcp_seq_num_i == rcv_nxt_q);
  assign ack_hit   = f_ack & (tcp_ack_num_i == snd_nxt_q);
  assign seg_end   = tcp_seq_num_i + {16'd0, tcp_data_len_i};
  assign rx_state  = state_q inside {ESTABLISHED, FIN_WAIT1, FIN_WAIT2};
  assign timed     = state_q inside {SYN_SENT, FIN_WAIT1, CLOSING, LAST_ACK, TIME_WAIT};
  assign rto_exp   = (tmr_q >= RTO_CYCLES - 32'd1);
  assign tw_exp    = (tmr_q >= TIME_WAIT_CYCLES - 32'd1);
  assign close_req = close_i | close_q;

  // NOTE: every signal gets a default before the branches so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    snd_nxt_d  = snd_nxt_q;
    rcv_nxt_d  = rcv_nxt_q;
    send       = 1'b0;
    snd_hdr    = mk(F_ACK, snd_nxt_q, rcv_nxt_q, 4'd5);
    data_ok    = 1'b0;
    win_upd    = 1'b0;
    err        = 1'b0;
    tmr_clr    = 1'b0;
    retry_inc  = 1'b0;
    close_take = 1'b0;
    if (state_q == CLOSED) begin
      if (open_i) begin
        send      = 1'b1;
        snd_hdr   = mk(F_SYN, ISS, 32'd0, 4'd8);
        snd_nxt_d = ISS + 32'd1;
        state_d   = SYN_SENT;
      end else if (seg_ok && !f_rst) begin
        send    = 1'b1;
        snd_hdr = f_ack ? mk(F_RST, tcp_ack_num_i, 32'd0, 4'd5) : mk(F_RST | F_ACK, 32'd0, seg_end, 4'd5);
      end
    end else if (seg_ok) begin
      if (state_q == SYN_SENT) begin
        if (f_ack && !ack_hit) begin
          if (!f_rst) begin
            send    = 1'b1;
            snd_hdr = mk(F_RST, tcp_ack_num_i, 32'd0, 4'd5);
          end
        end else if (f_rst) begin
          if (f_ack) state_d = CLOSED;
        end else if (f_syn && f_ack) begin
          rcv_nxt_d = tcp_seq_num_i + 32'd1;
          win_upd   = 1'b1;
          send      = 1'b1;
          snd_hdr   = mk(F_ACK, snd_nxt_q, rcv_nxt_d, 4'd5);
          state_d   = ESTABLISHED;
        end
      end else if (f_rst) begin
        if (seq_ok) state_d = CLOSED;
      end else begin
        win_upd = f_ack;
        if (f_syn) begin
          send = 1'b1;
        end else if (f_fin && seq_ok && rx_state) begin
          rcv_nxt_d = seg_end + 32'd1;
          data_ok   = (tcp_data_len_i != 16'd0);
          send      = 1'b1;
          snd_hdr   = mk(F_ACK, snd_nxt_q, rcv_nxt_d, 4'd5);
          if (state_q == ESTABLISHED) begin
            snd_hdr.flags = F_FIN | F_ACK;
            snd_nxt_d     = snd_nxt_q + 32'd1;
            state_d       = LAST_ACK;
          end else if (state_q == FIN_WAIT1 && !ack_hit) begin
            state_d = CLOSING;
          end else begin
            state_d = TIME_WAIT;
          end
        end else if (f_fin) begin
          // Out-of-order or retransmitted FIN: re-ACK; in TIME_WAIT it also restarts the dwell.
          send    = 1'b1;
          tmr_clr = (state_q == TIME_WAIT);
        end else begin
          if (rx_state && tcp_data_len_i != 16'd0) begin
            send = 1'b1;
            if (seq_ok) begin
              rcv_nxt_d   = seg_end;
              data_ok     = 1'b1;
              snd_hdr.ack = seg_end;
            end
          end
          if (ack_hit) begin
            case (state_q)
              FIN_WAIT1: state_d = FIN_WAIT2;
              CLOSING:   state_d = TIME_WAIT;
              LAST_ACK:  state_d = CLOSED;
              default:   state_d = state_q;
            endcase
          end
        end
      end
    end else if (!seg_ev) begin
      if (state_q == TIME_WAIT) begin
        if (tw_exp) state_d = CLOSED;
      end else if (timed && rto_exp) begin
        if (retries_q == MAX_RETRIES) begin
          state_d = CLOSED;
          err     = 1'b1;
        end else begin
          send      = 1'b1;
          retry_inc = 1'b1;
          tmr_clr   = 1'b1;
          snd_hdr   = (state_q == SYN_SENT) ? mk(F_SYN, ISS, 32'd0, 4'd8)
                                            : mk(F_FIN | F_ACK, snd_nxt_q - 32'd1, rcv_nxt_q, 4'd5);
        end
      end else if (state_q == ESTABLISHED && close_req && !pend_q) begin
        send       = 1'b1;
        close_take = 1'b1;
        snd_hdr    = mk(F_FIN | F_ACK, snd_nxt_q, rcv_nxt_q, 4'd5);
        snd_nxt_d  = snd_nxt_q + 32'd1;
        state_d    = FIN_WAIT1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      snd_nxt_q  <= 32'd0;
      rcv_nxt_q  <= 32'd0;
      tmr_q      <= 32'd0;
      retries_q  <= 32'd0;
      rd_q       <= 1'b0;
      pend_q     <= 1'b0;
      close_q    <= 1'b0;
      rx_ok_q    <= 1'b0;
      err_q      <= 1'b0;
      rx_len_q   <= 16'd0;
      win_q      <= 16'd0;
      pend_hdr_q <= HDR_RESET;
      out_hdr_q  <= HDR_RESET;
    end else begin
      state_q   <= state_d;
      snd_nxt_q <= snd_nxt_d;
      rcv_nxt_q <= rcv_nxt_d;
      rd_q      <= tcp_op_rcv_i & ~rd_q & ~pend_q & ~trnsmt_busy_i & ~send;
      if (send) begin
        pend_q     <= 1'b1;
        pend_hdr_q <= snd_hdr;
      end else if (tcp_start_o) begin
        pend_q <= 1'b0;
      end
      if (tcp_start_o) out_hdr_q <= pend_hdr_q;
      if (state_d != state_q || tmr_clr || !timed) tmr_q <= 32'd0;
      else                                         tmr_q <= tmr_q + 32'd1;
      if (state_d != state_q) retries_q <= 32'd0;
      else if (retry_inc)     retries_q <= retries_q + 32'd1;
      close_q <= (state_q == ESTABLISHED) & (state_d == ESTABLISHED) & close_req & ~close_take;
      rx_ok_q <= data_ok;
      if (data_ok) rx_len_q <= tcp_data_len_i;
      if (win_upd) win_q <= tcp_window_i;
      err_q <= err;
    end
  end

  // Header fields switch with the start pulse itself and then hold until the next one.
  assign tcp_start_o       = pend_q & ~trnsmt_busy_i;
  assign hdr_view          = tcp_start_o ? pend_hdr_q : out_hdr_q;
  assign tcp_flags_o       = hdr_view.flags;
  assign tcp_seq_num_o     = hdr_view.seq;
  assign tcp_ack_num_o     = hdr_view.ack;
  assign tcp_head_len_o    = hdr_view.head_len;
  assign tcp_source_port_o = LOCAL_PORT;
  assign tcp_dest_port_o   = REMOTE_PORT;
  assign tcp_data_len_o    = 16'd0;
  assign tcp_op_rcv_rd_o   = rd_q;
  assign rx_data_ok_o      = rx_ok_q;
  assign rx_data_len_o     = rx_len_q;
  assign peer_window_o     = win_q;
  assign state_o           = state_q;
  assign error_o           = err_q;

endmodule

// File: tb/tb_tcp_client_controller.sv
// Scoreboard bench for tcp_client_controller: expected TX headers and RX lengths are queued with
// the stimulus and compared when the DUT pulses tcp_start_o / rx_data_ok_o.
module tb_tcp_client_controller;
  localparam logic [15:0] LP = 16'hF719;
  localparam logic [15:0] RP = 16'h1F90;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        open_i = 1'b0, close_i = 1'b0, tcp_op_rcv_i = 1'b0, trnsmt_busy_i = 1'b0;
  logic [15:0] tcp_source_port_i = RP, tcp_dest_port_i = LP, tcp_data_len_i = 16'd0, tcp_window_i = 16'd0;
  logic [5:0]  tcp_flags_i = 6'd0;
  logic [31:0] tcp_seq_num_i = 32'd0, tcp_ack_num_i = 32'd0;
  logic        tcp_op_rcv_rd_o, tcp_start_o, rx_data_ok_o, error_o;
  logic [15:0] tcp_source_port_o, tcp_dest_port_o, tcp_data_len_o, rx_data_len_o, peer_window_o;
  logic [5:0]  tcp_flags_o;
  logic [31:0] tcp_seq_num_o, tcp_ack_num_o;
  logic [3:0]  tcp_head_len_o;
  logic [7:0]  state_o;

  tcp_client_controller #(
    .LOCAL_PORT(LP), .REMOTE_PORT(RP), .ISS(32'h0), .RTO_CYCLES(32'd100),
    .MAX_RETRIES(32'd3), .TIME_WAIT_CYCLES(32'd200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .open_i(open_i), .close_i(close_i), .tcp_op_rcv_i(tcp_op_rcv_i),
    .tcp_source_port_i(tcp_source_port_i), .tcp_dest_port_i(tcp_dest_port_i),
    .tcp_flags_i(tcp_flags_i), .tcp_seq_num_i(tcp_seq_num_i), .tcp_ack_num_i(tcp_ack_num_i),
    .tcp_data_len_i(tcp_data_len_i), .tcp_window_i(tcp_window_i), .tcp_op_rcv_rd_o(tcp_op_rcv_rd_o),
    .trnsmt_busy_i(trnsmt_busy_i), .tcp_start_o(tcp_start_o),
    .tcp_source_port_o(tcp_source_port_o), .tcp_dest_port_o(tcp_dest_port_o),
    .tcp_flags_o(tcp_flags_o), .tcp_seq_num_o(tcp_seq_num_o), .tcp_ack_num_o(tcp_ack_num_o),
    .tcp_head_len_o(tcp_head_len_o), .tcp_data_len_o(tcp_data_len_o), .rx_data_ok_o(rx_data_ok_o),
    .rx_data_len_o(rx_data_len_o), .peer_window_o(peer_window_o), .state_o(state_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  flags;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [3:0]  hlen;
  } hdr_t;

  hdr_t        exp_tx[$];
  int unsigned exp_rx[$];
  int unsigned start_cyc[$];
  int unsigned cyc = 0;
  int          n_start = 0;
  int          checks = 0, errors = 0;
  hdr_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX scoreboard
  always @(negedge clk) begin
    if (rst_n && tcp_start_o) begin
      n_start++;
      start_cyc.push_back(cyc);
      if (exp_tx.size() == 0) begin
        check("tx_unexpected_flags", 32'(tcp_flags_o), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_tx.pop_front();
        check("tx_flags", 32'(tcp_flags_o), 32'(mon_e.flags));
        check("tx_seq", tcp_seq_num_o, mon_e.seq);
        check("tx_ack", tcp_ack_num_o, mon_e.ack);
        check("tx_head_len", 32'(tcp_head_len_o), 32'(mon_e.hlen));
        check("tx_ports", {tcp_source_port_o, tcp_dest_port_o}, {LP, RP});
      end
    end
  end

  // RX scoreboard
  always @(negedge clk) begin
    if (rst_n && rx_data_ok_o) begin
      if (exp_rx.size() == 0) check("rx_unexpected_len", 32'(rx_data_len_o), 32'hFFFF_FFFF);
      else                    check("rx_len", 32'(rx_data_len_o), exp_rx.pop_front());
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [5:0] fl, input logic [31:0] sq, input logic [31:0] ak,
                          input logic [3:0] hl);
    exp_tx.push_back('{flags: fl, seq: sq, ack: ak, hlen: hl});
  endtask

  task automatic pulse_open();
    open_i = 1'b1; tick(1); open_i = 1'b0;
  endtask

  task automatic pulse_close();
    close_i = 1'b1; tick(1); close_i = 1'b0;
  endtask

  // Present one descriptor, hold it until popped, optionally hold TX busy right after the pop.
  task automatic send_seg(input logic [5:0] fl, input logic [31:0] sq, input logic [31:0] ak,
                          input logic [15:0] len, input int busy_after = 0,
                          input logic [15:0] sport = RP);
    bit popped = 1'b0;
    tcp_source_port_i = sport; tcp_dest_port_i = LP; tcp_flags_i = fl;
    tcp_seq_num_i = sq; tcp_ack_num_i = ak; tcp_data_len_i = len;
    tcp_window_i = 16'h2000 + len;
    tcp_op_rcv_i = 1'b1;
    for (int i = 0; i < 100 && !popped; i++) begin
      @(negedge clk);
      popped = tcp_op_rcv_rd_o;
    end
    if (!popped) check("pop_timeout", 32'(tcp_op_rcv_rd_o), 32'd1);
    @(posedge clk); #1;
    tcp_op_rcv_i = 1'b0;
    if (busy_after > 0) begin
      trnsmt_busy_i = 1'b1;
      tick(busy_after);
      trnsmt_busy_i = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_tx.size() != 0; i++) tick(1);
    tick(2);
    check("tx_drain", 32'(exp_tx.size()), 32'd0);
    check("rx_drain", 32'(exp_rx.size()), 32'd0);
  endtask

  task automatic establish();
    exp_push(6'h02, 32'd0, 32'd0, 4'd8);
    pulse_open();
    drain();
    exp_push(6'h10, 32'd1, 32'd1001, 4'd5);
    send_seg(6'h12, 32'd1000, 32'd1, 16'd0);
    drain();
    check("state_est", 32'(state_o), 32'h04);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_err;
    int unsigned err_cyc, idle_cyc;
    int n0;

    tick(3);
    check("rst_state", 32'(state_o), 32'h01);
    check("rst_head_len", 32'(tcp_head_len_o), 32'd5);
    check("rst_ports", {tcp_source_port_o, tcp_dest_port_o}, {LP, RP});
    check("rst_outs", {26'(tcp_flags_o), 1'(tcp_start_o), 1'(rx_data_ok_o), 1'(error_o),
                       1'(tcp_op_rcv_rd_o), 2'd0}, 32'd0);
    check("rst_seq_ack", tcp_seq_num_o | tcp_ack_num_o, 32'd0);
    check("rst_win_len", {peer_window_o, rx_data_len_o | tcp_data_len_o}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Open handshake
    establish();
    check("peer_window", 32'(peer_window_o), 32'h2000);

    // In-order data, then a duplicate
    exp_rx.push_back(100);
    exp_push(6'h10, 32'd1, 32'd1101, 4'd5);
    send_seg(6'h18, 32'd1001, 32'd1, 16'd100);
    drain();
    exp_push(6'h10, 32'd1, 32'd1101, 4'd5);
    send_seg(6'h18, 32'd1001, 32'd1, 16'd100);
    drain();

    // Active close through FIN_WAIT2 and TIME_WAIT
    exp_push(6'h11, 32'd1, 32'd1101, 4'd5);
    pulse_close();
    drain();
    check("state_fw1", 32'(state_o), 32'h08);
    send_seg(6'h10, 32'd1101, 32'd2, 16'd0);
    tick(2);
    check("state_fw2", 32'(state_o), 32'h10);
    exp_push(6'h10, 32'd2, 32'd1102, 4'd5);
    send_seg(6'h11, 32'd1101, 32'd2, 16'd0);
    check("state_tw", 32'(state_o), 32'h40);
    tick(199);
    check("state_tw_end", 32'(state_o), 32'h40);
    tick(1);
    check("state_tw_closed", 32'(state_o), 32'h01);
    drain();

    // Passive close
    establish();
    exp_rx.push_back(100);
    exp_push(6'h10, 32'd1, 32'd1101, 4'd5);
    send_seg(6'h18, 32'd1001, 32'd1, 16'd100);
    drain();
    exp_push(6'h11, 32'd1, 32'd1102, 4'd5);
    send_seg(6'h11, 32'd1101, 32'd1, 16'd0);
    drain();
    check("state_last_ack", 32'(state_o), 32'h80);
    send_seg(6'h10, 32'd1102, 32'd2, 16'd0);
    tick(2);
    check("state_la_closed", 32'(state_o), 32'h01);

    // Segments arriving in CLOSED
    exp_push(6'h04, 32'd77, 32'd0, 4'd5);
    send_seg(6'h18, 32'd5, 32'd77, 16'd10);
    exp_push(6'h14, 32'd0, 32'd510, 4'd5);
    send_seg(6'h02, 32'd500, 32'd0, 16'd10);
    send_seg(6'h10, 32'd1, 32'd1, 16'd0, 0, 16'h1234);
    drain();

    // Unanswered SYN: three resends RTO apart, then abort
    for (int i = 0; i < 4; i++) exp_push(6'h02, 32'd0, 32'd0, 4'd8);
    start_cyc.delete();
    pulse_open();
    got_err = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 600 && !got_err; i++) begin
      @(negedge clk);
      got_err = error_o;
      err_cyc = cyc;
    end
    check("err_pulse", 32'(got_err), 32'd1);
    check("syn_sends", 32'(start_cyc.size()), 32'd4);
    for (int i = 1; i < start_cyc.size(); i++) check("rto_gap", start_cyc[i] - start_cyc[i-1], 32'd100);
    if (start_cyc.size() > 0) check("err_gap", err_cyc - start_cyc[start_cyc.size()-1], 32'd100);
    tick(1);
    check("state_abort", 32'(state_o), 32'h01);
    check("err_one_cycle", 32'(error_o), 32'd0);
    drain();

    // Bad ACK in SYN_SENT, busy TX around SYN+ACK, then RST
    exp_push(6'h02, 32'd0, 32'd0, 4'd8);
    pulse_open();
    drain();
    exp_push(6'h04, 32'd5, 32'd0, 4'd5);
    send_seg(6'h12, 32'd1000, 32'd5, 16'd0);
    drain();
    check("state_syn_sent", 32'(state_o), 32'h02);
    exp_push(6'h10, 32'd1, 32'd1001, 4'd5);
    start_cyc.delete();
    n0 = n_start;
    send_seg(6'h12, 32'd1000, 32'd1, 16'd0, 20);
    idle_cyc = cyc;
    drain();
    check("busy_single_start", 32'(n_start - n0), 32'd1);
    if (start_cyc.size() > 0) check("busy_first_idle", start_cyc[0], idle_cyc);
    check("state_est_busy", 32'(state_o), 32'h04);
    send_seg(6'h04, 32'd1001, 32'd0, 16'd0);
    tick(2);
    check("state_rst", 32'(state_o), 32'h01);
    drain();

    // Reset while a SYN is pending behind a busy builder
    trnsmt_busy_i = 1'b1;
    pulse_open();
    tick(2);
    check("state_pend_syn", 32'(state_o), 32'h02);
    rst_n = 1'b0;
    tick(1);
    check("state_mid_reset", 32'(state_o), 32'h01);
    rst_n = 1'b1;
    trnsmt_busy_i = 1'b0;
    n0 = n_start;
    tick(5);
    check("no_send_after_reset", 32'(n_start - n0), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
